// File: rtl/mac_array_acc_if.sv
// mac_array_acc_if
//   Stream bundle for the mac_array_acc dot-product engine.
//   Input side : in_valid/in_ready handshake, in_last marks the final beat of
//                a dot product, in_a/in_b carry LANES packed signed operands
//                (lane i at bits [i*WIDTH +: WIDTH]).
//   Output side: out_valid/out_ready handshake, out_data is the signed
//                dot-product result, out_sat flags a clamped result.
//   Modports: master drives operands and consumes results (traffic source),
//             slave is the engine side.
interface mac_array_acc_if #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 2*WIDTH+8
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_last;
  logic [LANES*WIDTH-1:0]      in_a;
  logic [LANES*WIDTH-1:0]      in_b;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_data;
  logic                        out_sat;

  modport master (
    output in_valid, in_last, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_last, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mac_array_acc.sv
// mac_array_acc
//   Multi-lane signed multiply-accumulate engine. Each accepted beat
//   contributes sum_i(a[i]*b[i]); beats are accumulated until a beat tagged
//   in_last, whose completion delivers the dot product on the output side.
//   Pipeline: S1 lane products, S2 sign-extended lane sum, S3 accumulate and
//   result register. A held, unconsumed result freezes the whole pipeline.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mac_array_acc_if.slave (input beats and output results)
//   busy  - high while any beat is in flight, a partial product is pending
//           or a result is held
// Build option:
//   MAC_ARRAY_SAT_EN - when defined, accumulation saturates to the signed
//   ACC_WIDTH range and out_sat reports any clamp within the product;
//   otherwise accumulation wraps and out_sat is 0.
// ACC_WIDTH must be at least 2*WIDTH+log2(LANES) so the per-beat lane sum
// never overflows.
module mac_array_acc #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_array_acc_if.slave bus,
  output logic           busy
);

  localparam int PW = 2*WIDTH;

  logic advance;
  logic first_pend;
  logic out_valid_q;
  logic signed [ACC_WIDTH-1:0] out_data_q;

  logic signed [PW-1:0] prod_c [LANES];
  logic signed [PW-1:0] prod_p1 [LANES];
  logic                 vld_p1, first_p1, last_p1;

  logic signed [ACC_WIDTH-1:0] tree_sum;
  logic signed [ACC_WIDTH-1:0] sum_p2;
  logic                        vld_p2, first_p2, last_p2;

  logic signed [ACC_WIDTH-1:0] acc_p3;
  logic signed [ACC_WIDTH-1:0] acc_next;

`ifdef MAC_ARRAY_SAT_EN
  function automatic logic signed [ACC_WIDTH:0] add_wide(
    input logic signed [ACC_WIDTH-1:0] x,
    input logic signed [ACC_WIDTH-1:0] y
  );
    return {x[ACC_WIDTH-1], x} + {y[ACC_WIDTH-1], y};
  endfunction

  function automatic logic overflow(input logic signed [ACC_WIDTH:0] v);
    return v[ACC_WIDTH] != v[ACC_WIDTH-1];
  endfunction

  // Clamp toward the sign of the true (wide) result.
  function automatic logic signed [ACC_WIDTH-1:0] saturate(
    input logic signed [ACC_WIDTH:0] v
  );
    if (overflow(v))
      return {v[ACC_WIDTH], {(ACC_WIDTH-1){~v[ACC_WIDTH]}}};
    return v[ACC_WIDTH-1:0];
  endfunction

  logic signed [ACC_WIDTH:0] acc_wide;
  logic                      clamp;
  logic                      sat_p3, sat_next, out_sat_q;

  assign acc_wide = add_wide(acc_p3, sum_p2);
  assign clamp    = !first_p2 && overflow(acc_wide);
  assign acc_next = first_p2 ? sum_p2 : saturate(acc_wide);
  assign sat_next = clamp || (!first_p2 && sat_p3);
`else
  assign acc_next = first_p2 ? sum_p2 : acc_p3 + sum_p2;
`endif

  // A held result that is not being taken stalls every stage.
  assign advance      = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy = vld_p1 || vld_p2 || out_valid_q || !first_pend;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_c[i] = PW'($signed(bus.in_a[i*WIDTH +: WIDTH])) *
                  PW'($signed(bus.in_b[i*WIDTH +: WIDTH]));
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + ACC_WIDTH'(prod_p1[i]);
    end
  end

  // ---- S1 / S2 data registers (enable-only, no reset) ----
  always_ff @(posedge clk) begin
    if (advance) begin
      if (bus.in_valid) begin
        for (int i = 0; i < LANES; i++) prod_p1[i] <= prod_c[i];
        first_p1 <= first_pend;
        last_p1  <= bus.in_last;
      end
      if (vld_p1) begin
        sum_p2   <= tree_sum;
        first_p2 <= first_p1;
        last_p2  <= last_p1;
      end
    end
  end

  // ---- control, S3 accumulator and result register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_pend  <= 1'b1;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      acc_p3      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (advance) begin
      if (bus.in_valid) first_pend <= bus.in_last;
      vld_p1 <= bus.in_valid;
      vld_p2 <= vld_p1;
      if (vld_p2) acc_p3 <= acc_next;
      if (vld_p2 && last_p2) begin
        out_data_q  <= acc_next;
        out_valid_q <= 1'b1;
      end else begin
        // advance with a held result implies out_ready: it is consumed now
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef MAC_ARRAY_SAT_EN
  // Sticky clamp flag restarts with each product's first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_p3    <= 1'b0;
      out_sat_q <= 1'b0;
    end else if (advance && vld_p2) begin
      sat_p3 <= sat_next;
      if (last_p2) out_sat_q <= sat_next;
    end
  end

  assign bus.out_sat = out_sat_q;
`else
  assign bus.out_sat = 1'b0;
`endif

endmodule

// File: doc/mac_array_acc.md
MAC_ARRAY_ACC -- requirements
Module: mac_array_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, signed operand width per lane.
REQ-002 SHALL have parameter LANES, default 4, parallel multiply lanes (power of two, 1..16).
REQ-003 SHALL have parameter ACC_WIDTH, default 2*WIDTH+8, signed accumulator/result width; legal only if >= 2*WIDTH+log2(LANES).
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: in_valid  in  1  beat offered; in_ready  out  1  beat accepted when both high; in_last  in  1  final beat of current dot product.
REQ-006 SHALL have ports: in_a  in  LANES*WIDTH  packed signed operands, lane i at bits [i*WIDTH +: WIDTH]; in_b  in  LANES*WIDTH  same packing.
REQ-007 SHALL have ports: out_valid  out  1  result held; out_ready  in  1  result consumed when both high; out_data  out  ACC_WIDTH  signed dot-product result; out_sat  out  1  result clamped; busy  out  1  any beat in flight or result held.

Function
REQ-008 SHALL compute per dot product the sum over all accepted beats of sum over lanes of in_a[i]*in_b[i], full signed precision until accumulation.
REQ-009 SHALL be a 3-stage pipeline: S1 registers LANES products (2*WIDTH each); S2 registers sign-extended adder-tree sum; S3 accumulates.
REQ-010 SHALL define advance = !(out_valid && !out_ready); all stage registers and valid bits update only when advance is high, otherwise hold.
REQ-011 SHALL drive in_ready = advance combinationally; no combinational path from in_valid to in_ready.
REQ-012 SHALL tag each accepted beat "first" when it is the first beat after reset or after an accepted beat with in_last=1; tag travels with the beat.
REQ-013 SHALL in S3 load acc = S2 sum on a first beat, else acc = acc + S2 sum; bubbles leave acc unchanged.
REQ-014 SHALL, when a last-tagged beat completes S3, load out_data with the final accumulated value and set out_valid on that same edge; latency last-beat-acceptance edge to out_valid = 3 cycles.
REQ-015 SHALL accept a single-beat dot product (in_valid, in_last both high on a first beat) as a complete result.
REQ-016 SHALL allow back-to-back dot products with no idle cycle; next product's first beat may be accepted the cycle after the previous last beat.
REQ-017 SHALL clear out_valid on out_valid && out_ready unless a new result completes S3 on the same edge, in which case out_valid stays high with new data.
REQ-018 SHALL hold out_data and out_sat stable while out_valid && !out_ready.
REQ-019 SHALL drive busy high when any S1/S2/S3 valid bit, out_valid, or a partial (non-final) accumulation is pending.
REQ-020 SHALL ignore in_a, in_b, in_last when in_valid is low or in_ready is low.

Reset
REQ-021 SHALL on rst_n low, asynchronously: all stage valid bits 0, acc 0, out_data 0, out_valid 0, out_sat 0, busy 0, first-tag state = next beat is first.
REQ-022 SHALL discard any partial dot product and pending result on reset mid-operation; first post-reset beat starts a new product.
REQ-023 SHALL drive in_ready high during and immediately after reset (out_valid is 0).

Configuration
REQ-024 SHALL honour macro MAC_ARRAY_SAT_EN: when defined, each S3 update clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], and a sticky per-product flag set by any clamp is delivered as out_sat with the result, cleared on the next first beat.
REQ-025 SHALL when MAC_ARRAY_SAT_EN is undefined wrap modulo 2^ACC_WIDTH and tie out_sat to 0.

Verification
REQ-026 SHALL cover: WIDTH=8, LANES=4, one beat a={1,2,3,4}, b={5,6,7,8}, last=1, out_ready=1 -> out_data=70 exactly 3 cycles after acceptance, out_valid for 1 cycle.
REQ-027 SHALL cover: 3 beats a={-128}x4, b={-128}x4 -> out_data=196608; then immediately a={1}x4, b={-1}x4 last=1 -> out_data=-4, no idle cycle between products.
REQ-028 SHALL cover: out_ready held 0 while two products complete -> in_ready drops the cycle first result is held, second result and pipeline freeze, no beat lost; releasing out_ready delivers both in order.
REQ-029 SHALL cover: ACC_WIDTH=18, MAC_ARRAY_SAT_EN defined, 5 beats of 4*(127*127) -> out_data=131071, out_sat=1; undefined -> out_data=322580 mod 2^18 as signed (60436), out_sat=0.
REQ-030 SHALL cover: rst_n pulsed low after 2 of 4 beats -> outputs zero immediately; next beat with last=1 a={2}x4, b={3}x4 -> out_data=24.
